// File: rtl/seq_divider.sv
// Sequential unsigned 16-bit divider using repeated subtraction over a shared operand bus.
// Optional divide-by-zero flag port 'err' is built when the DIV_ERR_EN macro is defined.
module seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] data_in,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        busy,
`ifdef DIV_ERR_EN
  output logic        err,
`endif
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SUB  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] quo_q, quo_d;
  logic [15:0] div_q, div_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef DIV_ERR_EN
  logic        err_q, err_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 16'd0;
      quo_q   <= 16'd0;
      div_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DIV_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
`ifdef DIV_ERR_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) state_d = LDA;
      end
      LDA: begin
        rem_d   = data_in;
        state_d = LDB;
      end
      LDB: begin
        div_d = data_in;
        if (data_in != 16'd0) begin
          quo_d   = 16'd0;
          state_d = SUB;
        end else begin
          // Divide-by-zero: saturated quotient, dividend kept as remainder.
          quo_d   = 16'hFFFF;
          state_d = DONE;
`ifdef DIV_ERR_EN
          err_d   = 1'b1;
`endif
        end
      end
      SUB: begin
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
          quo_d = quo_q + 16'd1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_d = LDA;
`ifdef DIV_ERR_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
`ifdef DIV_ERR_EN
        err_d   = 1'b0;
`endif
      end
    endcase

    busy_d = (state_d == LDA) || (state_d == LDB) || (state_d == SUB);
    // done follows DONE by one edge but drops on the same edge a new start leaves DONE.
    done_d = (state_q == DONE) && (state_d == DONE);
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef DIV_ERR_EN
  assign err       = err_q;
`endif

endmodule
